miriscv_mem_arbiter: RTL

- Two-port arbiter sharing the single data-memory port between the core LSU (port 0) and a secondary master such as a DMA or debug unit (port 1).
- Selects one requester and latches its request.
- Issues that request to memory as a one-cycle pulse.
- Waits a fixed read latency, then returns read data and a completion strobe to the winning port.
- Generates the stall request for the core while the LSU access is outstanding.

---
 rtl/miriscv_mem_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/miriscv_mem_arbiter.sv
// miriscv_mem_arbiter
//   Shares the single data-memory port between the core LSU (port 0) and a
//   secondary master such as DMA or debug (port 1). A winner is granted in
//   IDLE, its request is latched, issued to memory as a one-cycle pulse
//   (ISSUE), and after MEM_LATENCY cycles (WAIT) the read data and a
//   completion strobe are returned to the winning port.
//
//   Parameters:
//     MEM_LATENCY  cycles from the mem_req_o cycle to valid mem_rdata_i (1..7)
//
//   Optional feature macro:
//     ARB_ROUND_ROBIN_EN  when defined, simultaneous requests alternate
//                         between ports; otherwise port 0 has fixed priority.
//
//   Ports:
//     clk_i, arstn_i                         clock, async active-high reset
//     p0_req/we/be/addr/wdata_i              port 0 (LSU) request
//     p0_gnt_o, p0_rvalid_o, p0_rdata_o      port 0 grant / completion / data
//     p0_stall_o                             core stall request
//     p1_req/we/be/addr/wdata_i              port 1 request
//     p1_gnt_o, p1_rvalid_o, p1_rdata_o      port 1 grant / completion / data
//     mem_req/we/be/addr/wdata_o             memory request
//     mem_rdata_i                            memory read data
//     busy_o                                 arbiter in ISSUE or WAIT
module miriscv_mem_arbiter #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        p0_req_i,
  input  logic        p0_we_i,
  input  logic [3:0]  p0_be_i,
  input  logic [31:0] p0_addr_i,
  input  logic [31:0] p0_wdata_i,
  output logic        p0_gnt_o,
  output logic        p0_rvalid_o,
  output logic [31:0] p0_rdata_o,
  output logic        p0_stall_o,
  input  logic        p1_req_i,
  input  logic        p1_we_i,
  input  logic [3:0]  p1_be_i,
  input  logic [31:0] p1_addr_i,
  input  logic [31:0] p1_wdata_i,
  output logic        p1_gnt_o,
  output logic        p1_rvalid_o,
  output logic [31:0] p1_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  cnt;
  logic        lat_we;
  logic [3:0]  lat_be;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        lat_id;
  logic        win;
  logic        any_req;
  logic        take;
  logic        rvalid;

`ifdef ARB_ROUND_ROBIN_EN
  logic        last_grant;
`endif

  assign any_req = p0_req_i | p1_req_i;

  // Winner id: 0 = port 0, 1 = port 1. Only meaningful when any_req is set.
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    if (p0_req_i && p1_req_i) begin
      win = ~last_grant;
    end else begin
      win = ~p0_req_i;
    end
`else
    win = ~p0_req_i;
`endif
  end

  // Grants are combinational from the request inputs, so they are gated with
  // the reset to keep every output at 0 while reset is held.
  assign take     = (state == ST_IDLE) & any_req & ~arstn_i;
  assign p0_gnt_o = take & ~win;
  assign p1_gnt_o = take & win;

  always_ff @(posedge clk_i or posedge arstn_i) begin
    if (arstn_i) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_be    <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_id    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant <= 1'b1;
`endif
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && any_req) begin
        lat_id    <= win;
        lat_we    <= win ? p1_we_i    : p0_we_i;
        lat_be    <= win ? p1_be_i    : p0_be_i;
        lat_addr  <= win ? p1_addr_i  : p0_addr_i;
        lat_wdata <= win ? p1_wdata_i : p0_wdata_i;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant <= win;
`endif
      end
      if (state == ST_ISSUE) begin
        cnt <= 3'(MEM_LATENCY);
      end else if (state == ST_WAIT) begin
        cnt <= cnt - 3'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (any_req) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (cnt == 3'd1) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign rvalid      = (state == ST_WAIT) && (cnt == 3'd1);
  assign p0_rvalid_o = rvalid & ~lat_id;
  assign p1_rvalid_o = rvalid & lat_id;
  assign p0_rdata_o  = (p0_rvalid_o && !lat_we) ? mem_rdata_i : '0;
  assign p1_rdata_o  = (p1_rvalid_o && !lat_we) ? mem_rdata_i : '0;
  assign p0_stall_o  = p0_req_i & ~p0_rvalid_o & ~arstn_i;

  assign mem_req_o   = (state == ST_ISSUE);
  assign mem_we_o    = lat_we;
  assign mem_be_o    = lat_be;
  assign mem_addr_o  = lat_addr;
  assign mem_wdata_o = lat_wdata;
  assign busy_o      = (state != ST_IDLE);

endmodule
